// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Memory side of the MEM-stage load/store interface. Accepts one
//            request at a time and serves a 64-bit doubleword load or a
//            byte-strobed store after a programmable number of wait states.
//            It returns the load data or an error flag over a response channel.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int                DEPTH_WORDS = 256,
  parameter int                ADDR_W      = 64,
  parameter int                LATENCY     = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err
);

  localparam int                IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_WORDS);
  localparam logic [3:0]        LAT_C   = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Request fields are frozen at the accept edge; later input changes are ignored.
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [63:0]       cap_wdata;
  logic [7:0]        cap_wstrb;
  logic [3:0]        cnt;

  logic [63:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              access;
  logic              handshake;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              acc_err;

  // Address decode of the captured request: alignment, lower bound and upper bound.
  always_comb begin
    offset   = cap_addr - BASE_ADDR;
    word_idx = offset >> 3;
    mem_idx  = word_idx[IDX_W-1:0];
    acc_err  = (cap_addr[2:0] != 3'b000) | (cap_addr < BASE_ADDR) | (word_idx >= DEPTH_A);
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    handshake = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = ~rst;
        accept    = req_valid & ~rst;
        if (accept) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        handshake = resp_ready;
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign resp_valid = (state == S_RESP);

  // Capture the request at accept and count down the wait states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      cnt       <= '0;
    end else if (accept) begin
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_wstrb <= req_wstrb;
      cnt       <= LAT_C;
    end else if (state == S_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response payload is loaded at the access edge and held until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (access) begin
      resp_err   <= acc_err;
      resp_rdata <= (acc_err || cap_write) ? 64'd0 : mem[mem_idx];
    end else if (handshake) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end
  end

  // Array write: committed only at the access edge of an in-range store.
  always_ff @(posedge clk) begin
    if (access && cap_write && !acc_err) begin
      for (int i = 0; i < 8; i++) begin
        if (cap_wstrb[i]) mem[mem_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire
